// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
// RXD is synchronised, the start bit is checked at its midpoint, data bits are
// sampled at their midpoints LSB first, and the stop bit is validated.
// Good bytes land in a one-entry valid/ready holding register; UART_RTS tells the
// far-end transmitter whether that register has room.
module uart_rx #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       ACLK,
    input  logic       RESET_N,
    input  logic       RXD,
    output logic [7:0] RX_DATA,
    output logic       RX_DATA_VALID,
    input  logic       RX_DATA_READY,
    output logic       UART_RTS,
    output logic       RX_IDLE,
    output logic       FRAME_ERR,
    output logic       RX_OVERRUN,
    input  logic       OVERRUN_CLR
);

    localparam int CLOCKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_BIT       = CLOCKS_PER_BIT / 2;
    localparam int CNT_W          = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK_WAIT
    } state_t;

    // Synchroniser flops; both idle high so reset never looks like a start edge.
    logic             rxd_meta_reg;
    logic             rxd_s_reg;

    // Frame FSM state.
    state_t           state_reg,     state_next;
    logic [CNT_W-1:0] cnt_reg,       cnt_next;
    logic [2:0]       bit_idx_reg,   bit_idx_next;
    logic [7:0]       rx_shift_reg,  rx_shift_next;

    // One-cycle strobes out of the FSM: a good byte is ready, or the stop bit was low.
    logic             deliver_reg,   deliver_next;
    logic             frame_err_reg, frame_err_next;

    // Consumer-side holding register.
    logic [7:0]       rx_data_reg;
    logic             valid_reg;
    logic             overrun_reg;

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge ACLK) begin
        if (!RESET_N) begin
            rxd_meta_reg <= 1'b1;
            rxd_s_reg    <= 1'b1;
        end else begin
            rxd_meta_reg <= RXD;
            rxd_s_reg    <= rxd_meta_reg;
        end
    end

    // FSM state register together with the bit timing counter and shift register.
    always_ff @(posedge ACLK) begin
        if (!RESET_N) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            rx_shift_reg  <= '0;
            deliver_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_idx_reg   <= bit_idx_next;
            rx_shift_reg  <= rx_shift_next;
            deliver_reg   <= deliver_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // Next-state logic: start validation, midpoint sampling and stop-bit check.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bit_idx_next   = bit_idx_reg;
        rx_shift_next  = rx_shift_reg;
        deliver_next   = 1'b0;
        frame_err_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                cnt_next     = '0;
                bit_idx_next = '0;
                if (!rxd_s_reg) begin
                    state_next = ST_START;
                end
            end

            ST_START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next = '0;
                    if (!rxd_s_reg) begin
                        // Still low at mid start bit: a real frame.
                        state_next   = ST_DATA;
                        bit_idx_next = '0;
                    end else begin
                        // Line went back high: a glitch, drop it silently.
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next                   = '0;
                    rx_shift_next[bit_idx_reg] = rxd_s_reg;
                    bit_idx_next               = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next = '0;
                    if (rxd_s_reg) begin
                        deliver_next = 1'b1;
                        state_next   = ST_IDLE;
                    end else begin
                        // Low stop bit: flag it and wait out the break.
                        frame_err_next = 1'b1;
                        state_next     = ST_BREAK_WAIT;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_BREAK_WAIT: begin
                cnt_next = '0;
                if (rxd_s_reg) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Holding register: load on deliver when empty or being drained, else flag overrun.
    always_ff @(posedge ACLK) begin
        if (!RESET_N) begin
            rx_data_reg <= 8'h00;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (deliver_reg) begin
                if (!valid_reg || RX_DATA_READY) begin
                    rx_data_reg <= rx_shift_reg;
                    valid_reg   <= 1'b1;
                end
            end else if (valid_reg && RX_DATA_READY) begin
                valid_reg <= 1'b0;
            end

            // A lost byte wins over a simultaneous clear so no loss goes unreported.
            if (deliver_reg && valid_reg && !RX_DATA_READY) begin
                overrun_reg <= 1'b1;
            end else if (OVERRUN_CLR) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign RX_DATA       = rx_data_reg;
    assign RX_DATA_VALID = valid_reg;
    assign UART_RTS      = ~valid_reg;
    assign RX_IDLE       = (state_reg == ST_IDLE);
    assign FRAME_ERR     = frame_err_reg;
    assign RX_OVERRUN    = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Stimulus pushes expected bytes,
// a negedge monitor pops them whenever the consumer handshake completes.
module tb_uart_rx;

    localparam int CF        = 1_000_000;
    localparam int BR        = 100_000;
    localparam int CPB       = CF / BR;
    localparam int HALF      = CPB / 2;
    // Driven start edge -> VALID high: 2 sync flops, 1 cycle for IDLE to see it,
    // half a bit to the start check, 9 bit periods to the stop sample, 1 to deliver.
    localparam int VALID_LAT = 2 + 1 + HALF + 9 * CPB + 1;

    logic       ACLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       RXD = 1'b1;
    logic [7:0] RX_DATA;
    logic       RX_DATA_VALID;
    logic       RX_DATA_READY = 1'b0;
    logic       UART_RTS;
    logic       RX_IDLE;
    logic       FRAME_ERR;
    logic       RX_OVERRUN;
    logic       OVERRUN_CLR = 1'b0;

    uart_rx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
        .ACLK          (ACLK),
        .RESET_N       (RESET_N),
        .RXD           (RXD),
        .RX_DATA       (RX_DATA),
        .RX_DATA_VALID (RX_DATA_VALID),
        .RX_DATA_READY (RX_DATA_READY),
        .UART_RTS      (UART_RTS),
        .RX_IDLE       (RX_IDLE),
        .FRAME_ERR     (FRAME_ERR),
        .RX_OVERRUN    (RX_OVERRUN),
        .OVERRUN_CLR   (OVERRUN_CLR)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    int         exp_fe = 0;
    int         fe_count = 0;
    int         start_cyc = 0;
    int         valid_rise_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_data"},  RX_DATA, 8'h00);
        check({tag, "_valid"},    RX_DATA_VALID, 1'b0);
        check({tag, "_rts"},      UART_RTS, 1'b1);
        check({tag, "_idle"},     RX_IDLE, 1'b1);
        check({tag, "_frame_err"}, FRAME_ERR, 1'b0);
        check({tag, "_overrun"},  RX_OVERRUN, 1'b0);
    endtask

    // Drive one 10-bit frame, one bit per CPB cycles. Optionally pulse READY so it
    // is sampled on the deliver edge, or assert reset for one edge at reset_step.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input bit ready_on_deliver, input int reset_step);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int j = 0; j < 10 * CPB; j++) begin
            @(posedge ACLK);
            #1;
            if (j == 0) start_cyc = cyc;
            RXD = bits[j / CPB];
            if (ready_on_deliver) RX_DATA_READY = (j == VALID_LAT - 1);
            if (reset_step >= 0) begin
                if (j == reset_step) begin
                    RESET_N = 1'b0;
                    exp_q.delete();
                end
                if (j == reset_step + 1) begin
                    RESET_N = 1'b1;
                    check_reset_outputs("midframe_reset");
                end
            end
        end
    endtask

    task automatic drain();
        RX_DATA_READY = 1'b1;
        for (int k = 0; k < 20 && RX_DATA_VALID; k++) tick(1);
        RX_DATA_READY = 1'b0;
        check("drain_valid_clear", RX_DATA_VALID, 1'b0);
    endtask

    // Monitor: handshake scoreboard, RTS/VALID relation, FRAME_ERR pulse width.
    initial begin
        logic prev_valid;
        logic prev_fe;
        prev_valid = 1'b0;
        prev_fe    = 1'b0;
        forever begin
            @(negedge ACLK);
            if (RESET_N) begin
                if (RX_DATA_VALID && RX_DATA_READY) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_transfer: got 0x%0h, expected no byte", RX_DATA);
                    end else begin
                        check("rx_data_transfer", RX_DATA, exp_q.pop_front());
                    end
                end
                check("rts_is_not_valid", UART_RTS, !RX_DATA_VALID);
                if (FRAME_ERR) begin
                    fe_count++;
                    check("frame_err_one_cycle", prev_fe, 1'b0);
                end
                if (RX_DATA_VALID && !prev_valid) valid_rise_cyc = cyc;
            end
            prev_valid = RX_DATA_VALID;
            prev_fe    = FRAME_ERR;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        RESET_N = 1'b0;
        tick(3);
        check_reset_outputs("reset");
        RESET_N = 1'b1;
        tick(5);

        // 0xA5 with READY low: latency, hold, then single-edge READY
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        tick(5);
        check("a5_valid_latency", valid_rise_cyc - start_cyc, VALID_LAT);
        check("a5_valid", RX_DATA_VALID, 1'b1);
        check("a5_data", RX_DATA, 8'hA5);
        check("a5_rts_low", UART_RTS, 1'b0);
        tick(10);
        check("a5_valid_held", RX_DATA_VALID, 1'b1);
        RX_DATA_READY = 1'b1;
        tick(1);
        RX_DATA_READY = 1'b0;
        check("a5_valid_cleared", RX_DATA_VALID, 1'b0);
        check("a5_rts_high", UART_RTS, 1'b1);

        // Start-bit glitch of 3 cycles
        tick(1);
        RXD = 1'b0;
        tick(3);
        RXD = 1'b1;
        check("glitch_in_start", RX_IDLE, 1'b0);
        tick(20);
        check("glitch_back_idle", RX_IDLE, 1'b1);
        check("glitch_no_valid", RX_DATA_VALID, 1'b0);
        check("glitch_no_frame_err", fe_count, exp_fe);

        // 0x3C with low stop bit, then a 50-cycle break, then 0x81
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        exp_fe++;
        tick(50);
        check("break_waiting", RX_IDLE, 1'b0);
        check("break_no_valid", RX_DATA_VALID, 1'b0);
        check("break_frame_err_count", fe_count, exp_fe);
        RXD = 1'b1;
        tick(10);
        check("break_released", RX_IDLE, 1'b1);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0, -1);
        tick(3);
        check("after_break_valid", RX_DATA_VALID, 1'b1);
        drain();

        // Overrun: 0x11 then 0x22 with READY low
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, -1);
        tick(5);
        check("ovr_data_kept", RX_DATA, 8'h11);
        check("ovr_valid", RX_DATA_VALID, 1'b1);
        check("ovr_flag_set", RX_OVERRUN, 1'b1);
        OVERRUN_CLR = 1'b1;
        tick(1);
        OVERRUN_CLR = 1'b0;
        check("ovr_flag_cleared", RX_OVERRUN, 1'b0);
        drain();

        // Same pair, READY on the deliver edge of 0x22
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0, -1);
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1, 1'b1, -1);
        tick(3);
        check("handoff_data", RX_DATA, 8'h22);
        check("handoff_valid", RX_DATA_VALID, 1'b1);
        check("handoff_no_overrun", RX_OVERRUN, 1'b0);
        drain();

        // Reset mid data bit 4 of 0xFF while a byte is held
        exp_q.push_back(8'h77);
        send_frame(8'h77, 1'b1, 1'b0, -1);
        tick(3);
        check("pre_reset_valid", RX_DATA_VALID, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b0, 4 * CPB + CPB + HALF);
        tick(20);
        check("post_reset_no_valid", RX_DATA_VALID, 1'b0);
        check("post_reset_idle", RX_IDLE, 1'b1);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0, -1);
        tick(3);
        check("post_reset_5a_valid", RX_DATA_VALID, 1'b1);
        check("post_reset_5a_data", RX_DATA, 8'h5A);
        drain();

        // Randomised frames with an always-ready consumer
        RX_DATA_READY = 1'b1;
        for (int i = 0; i < 24; i++) begin
            logic [7:0] b;
            logic       stop;
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            if (stop) exp_q.push_back(b);
            send_frame(b, stop, 1'b0, -1);
            if (!stop) begin
                exp_fe++;
                tick($urandom_range(1, 30));
                RXD = 1'b1;
            end
            tick($urandom_range(2, 15));
        end
        tick(5);
        RX_DATA_READY = 1'b0;
        tick(5);

        check("final_queue_empty", exp_q.size(), 0);
        check("final_frame_err_count", fe_count, exp_fe);
        check("final_valid_low", RX_DATA_VALID, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
